// File: rtl/pipe3_flow_ctrl.sv
// -----------------------------------------------------------------------------
// pipe3_flow_ctrl
//
// Three-stage valid/ready pipeline computing out_data = in_a & in_b, with a
// small RUN / DRAIN / HALT controller that can stop intake, let the pipeline
// empty and then park the block idle until drain is released.
//
// Stage contents:
//   S1 : a1 = in_a, nb1 = ~in_b          (valid v1)
//   S2 : d2 = a1 & ~nb1                  (valid v2)
//   S3 : d3 = d2 -> out_data             (valid v3 -> out_valid)
//
// Load enables ripple backwards from the output so that a bubble anywhere in
// the pipeline is collapsed in a single cycle and full throughput is kept
// while out_ready stays high.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-low; clears all state immediately
//   in_valid   in   upstream beat present
//   in_ready   out  block accepts a beat this cycle (RUN state and S1 free)
//   in_a       in   operand A [WIDTH]
//   in_b       in   operand B [WIDTH]
//   out_valid  out  result present in S3
//   out_ready  in   downstream accepts result
//   out_data   out  result [WIDTH]
//   drain      in   level request: stop intake, empty pipeline, hold idle
//   idle       out  controller in HALT (pipeline empty)
//   occ        out  number of valid stages, 0..3
//   done_cnt   out  completed output transfers, wraps at 16 bits
// -----------------------------------------------------------------------------
module pipe3_flow_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             drain,
    output logic             idle,
    output logic [1:0]       occ,
    output logic [15:0]      done_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Controller state
    state_t state_r;
    state_t state_nxt_s;

    // Pipeline valid bits and their next values
    logic v1_r;
    logic v2_r;
    logic v3_r;
    logic v1_nxt_s;
    logic v2_nxt_s;
    logic v3_nxt_s;

    // Pipeline data registers
    logic [WIDTH-1:0] a1_r;
    logic [WIDTH-1:0] nb1_r;
    logic [WIDTH-1:0] d2_r;
    logic [WIDTH-1:0] d3_r;

    // Flow control
    logic ld1_s;
    logic ld2_s;
    logic ld3_s;
    logic run_s;
    logic in_fire_s;
    logic out_fire_s;

    // Registered status outputs
    logic [1:0]  occ_r;
    logic [1:0]  occ_nxt_s;
    logic        idle_r;
    logic [15:0] done_cnt_r;

    // Load enables: a stage may load when it is empty or its successor loads.
    always_comb begin
        ld3_s = ~v3_r | out_ready;
        ld2_s = ~v2_r | ld3_s;
        ld1_s = ~v1_r | ld2_s;
    end

    // Intake gating: only in RUN, and never while reset is held low, so that
    // in_ready reads 0 throughout reset even though the pipeline looks empty.
    always_comb begin
        run_s      = (state_r == ST_RUN);
        in_ready   = ld1_s & run_s & reset;
        in_fire_s  = in_valid & in_ready;
        out_fire_s = v3_r & out_ready;
    end

    // Next valid bits; a loading stage takes its predecessor's valid, which
    // clears it when no beat is behind it.
    always_comb begin
        v1_nxt_s = v1_r;
        v2_nxt_s = v2_r;
        v3_nxt_s = v3_r;
        if (ld1_s) begin
            v1_nxt_s = in_fire_s;
        end else begin
            v1_nxt_s = v1_r;
        end
        if (ld2_s) begin
            v2_nxt_s = v1_r;
        end else begin
            v2_nxt_s = v2_r;
        end
        if (ld3_s) begin
            v3_nxt_s = v2_r;
        end else begin
            v3_nxt_s = v3_r;
        end
        occ_nxt_s = {1'b0, v1_nxt_s} + {1'b0, v2_nxt_s} + {1'b0, v3_nxt_s};
    end

    // Controller next-state logic. DRAIN always runs to HALT even if drain
    // drops early, so the block passes through a clean empty point.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (drain) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (occ_r == 2'd0) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_HALT: begin
                if (!drain) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Controller state register and registered idle flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
            idle_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idle_r  <= (state_nxt_s == ST_HALT);
        end
    end

    // Pipeline valid bits and registered occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_r  <= 1'b0;
            v2_r  <= 1'b0;
            v3_r  <= 1'b0;
            occ_r <= 2'd0;
        end else begin
            v1_r  <= v1_nxt_s;
            v2_r  <= v2_nxt_s;
            v3_r  <= v3_nxt_s;
            occ_r <= occ_nxt_s;
        end
    end

    // Stage 1 data: captured only for an accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a1_r  <= {WIDTH{1'b0}};
            nb1_r <= {WIDTH{1'b0}};
        end else if (in_fire_s) begin
            a1_r  <= in_a;
            nb1_r <= ~in_b;
        end
    end

    // Stage 2 data: AND formed from the inverted-B copy held in S1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d2_r <= {WIDTH{1'b0}};
        end else if (ld2_s && v1_r) begin
            d2_r <= a1_r & ~nb1_r;
        end
    end

    // Stage 3 data: holds steady while the output is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d3_r <= {WIDTH{1'b0}};
        end else if (ld3_s && v2_r) begin
            d3_r <= d2_r;
        end
    end

    // Completed-transfer counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_cnt_r <= 16'd0;
        end else if (out_fire_s) begin
            done_cnt_r <= done_cnt_r + 16'd1;
        end
    end

    assign out_valid = v3_r;
    assign out_data  = d3_r;
    assign occ       = occ_r;
    assign idle      = idle_r;
    assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_pipe3_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe3_flow_ctrl
//
// Directed bench for pipe3_flow_ctrl: a per-cycle vector table for the single
// beat and stall/release cases, followed by hand-written sequences for
// back-to-back streaming, drain, reset mid-flight, drain held through reset
// and done_cnt wrap-around. Inputs change 1 ns after the rising edge and
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe3_flow_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             drain;
    logic             idle;
    logic [1:0]       occ;
    logic [15:0]      done_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    pipe3_flow_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drain     (drain),
        .idle      (idle),
        .occ       (occ),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ordy;
        logic        drn;
        logic        e_ir;
        logic        e_ov;
        logic [7:0]  e_data;
        logic [1:0]  e_occ;
        logic [15:0] e_done;
    } vec_t;

    vec_t vecs[14];

    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    initial begin
        int sent;
        int recv;
        int cyc;
        int first_out;
        int xfers;
        bit seen_ffff;
        bit seen_wrap;

        // Single beat F0 & 3C = 30, then three beats stalled and released.
        vecs[0]  = '{1'b1, 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 16'd0};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1, 16'd0};
        vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1, 16'd0};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h30, 2'd1, 16'd0};
        vecs[4]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 16'd1};
        vecs[5]  = '{1'b1, 8'hAA, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 16'd1};
        vecs[6]  = '{1'b1, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1, 16'd1};
        vecs[7]  = '{1'b1, 8'hFF, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2, 16'd1};
        vecs[8]  = '{1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd3, 16'd1};
        vecs[9]  = '{1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd3, 16'd1};
        vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0A, 2'd3, 16'd1};
        vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 2'd2, 16'd2};
        vecs[12] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81, 2'd1, 16'd3};
        vecs[13] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 16'd4};

        // ---------------- reset state ----------------
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b1;
        drain     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_data",  {24'd0, out_data},  32'd0);
        chk("rst occ",       {30'd0, occ},       32'd0);
        chk("rst done_cnt",  {16'd0, done_cnt},  32'd0);
        chk("rst idle",      {31'd0, idle},      32'd0);
        reset = 1'b1;
        next_cycle();

        // ---------------- vector table ----------------
        for (int i = 0; i < 14; i++) begin
            in_valid  = vecs[i].iv;
            in_a      = vecs[i].a;
            in_b      = vecs[i].b;
            out_ready = vecs[i].ordy;
            drain     = vecs[i].drn;
            @(negedge clk);
            chk($sformatf("row%0d in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
            chk($sformatf("row%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            if (vecs[i].e_ov) begin
                chk($sformatf("row%0d out_data", i), {24'd0, out_data}, {24'd0, vecs[i].e_data});
            end
            chk($sformatf("row%0d occ", i),      {30'd0, occ},      {30'd0, vecs[i].e_occ});
            chk($sformatf("row%0d done_cnt", i), {16'd0, done_cnt}, {16'd0, vecs[i].e_done});
            chk($sformatf("row%0d idle", i),     {31'd0, idle},     32'd0);
            next_cycle();
        end

        // ---------------- 10 back-to-back beats ----------------
        sent      = 0;
        recv      = 0;
        cyc       = 0;
        first_out = -1;
        out_ready = 1'b1;
        while (recv < 10 && cyc < 40) begin
            in_valid = (sent < 10);
            in_a     = 8'(sent * 17 + 3);
            in_b     = 8'(8'hF5 ^ (sent * 8'h0B));
            @(negedge clk);
            if (in_valid) begin
                chk($sformatf("b2b in_ready beat%0d", sent), {31'd0, in_ready}, 32'd1);
                if (in_ready) begin
                    exp_q.push_back(in_a & in_b);
                    sent++;
                end
            end
            if (out_valid && out_ready) begin
                if (first_out < 0) first_out = cyc;
                chk($sformatf("b2b gap out%0d", recv), cyc - first_out, recv);
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                chk($sformatf("b2b data out%0d", recv), {24'd0, out_data}, {24'd0, exp_v});
                recv++;
            end
            next_cycle();
            cyc++;
        end
        in_valid = 1'b0;
        chk("b2b outputs seen", recv, 10);
        @(negedge clk);
        chk("b2b done_cnt", {16'd0, done_cnt}, 32'd14);
        next_cycle();

        // ---------------- drain with occ=2 ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'hC3;
        in_b      = 8'hF0;
        next_cycle();
        in_a      = 8'h3C;
        in_b      = 8'h0F;
        next_cycle();
        in_valid  = 1'b0;
        drain     = 1'b1;
        @(negedge clk);
        chk("drn occ before", {30'd0, occ}, 32'd2);
        chk("drn in_ready first cycle", {31'd0, in_ready}, 32'd1);
        next_cycle();
        exp_q.delete();
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'h0C);
        in_valid  = 1'b1;
        in_a      = 8'hFF;
        in_b      = 8'hFF;
        out_ready = 1'b1;
        recv      = 0;
        cyc       = 0;
        @(negedge clk);
        chk("drn in_ready after", {31'd0, in_ready}, 32'd0);
        while (!idle && cyc < 20) begin
            if (in_ready) chk("drn in_ready held", {31'd0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                chk($sformatf("drn data out%0d", recv), {24'd0, out_data}, {24'd0, exp_v});
                recv++;
            end
            next_cycle();
            @(negedge clk);
            cyc++;
        end
        chk("drn reached idle", {31'd0, idle}, 32'd1);
        chk("drn outputs seen", recv, 2);
        chk("drn idle occ", {30'd0, occ}, 32'd0);
        chk("drn idle in_ready", {31'd0, in_ready}, 32'd0);
        chk("drn done_cnt", {16'd0, done_cnt}, 32'd16);
        next_cycle();
        in_valid = 1'b0;
        drain    = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("drn release in_ready", {31'd0, in_ready}, 32'd1);
        chk("drn release idle", {31'd0, idle}, 32'd0);
        next_cycle();

        // ---------------- reset mid-operation with occ=3 ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'h77;
        in_b      = 8'h7E;
        repeat (3) next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid occ full", {30'd0, occ}, 32'd3);
        next_cycle();
        #2;
        reset = 1'b0;
        #1;
        chk("mid out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid occ", {30'd0, occ}, 32'd0);
        chk("mid done_cnt", {16'd0, done_cnt}, 32'd0);
        chk("mid in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("mid no ghost %0d", k), {31'd0, out_valid}, 32'd0);
        end
        next_cycle();

        // ---------------- drain held through reset ----------------
        reset = 1'b0;
        drain = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rstdrn in_ready after first edge", {31'd0, in_ready}, 32'd0);
        chk("rstdrn idle first", {31'd0, idle}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rstdrn idle", {31'd0, idle}, 32'd1);
        drain = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("rstdrn back to run", {31'd0, in_ready}, 32'd1);
        next_cycle();

        // ---------------- done_cnt wrap ----------------
        reset = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'h5A;
        in_b      = 8'hFF;
        out_ready = 1'b1;
        xfers     = 0;
        seen_ffff = 1'b0;
        seen_wrap = 1'b0;
        for (int c = 0; c < 70000 && !seen_wrap; c++) begin
            @(negedge clk);
            if (xfers == 65535 && !seen_ffff) begin
                chk("wrap done_cnt ffff", {16'd0, done_cnt}, 32'h0000FFFF);
                seen_ffff = 1'b1;
            end
            if (xfers == 65536) begin
                chk("wrap done_cnt 0000", {16'd0, done_cnt}, 32'h00000000);
                seen_wrap = 1'b1;
            end
            if (out_valid && out_ready) xfers++;
        end
        in_valid = 1'b0;
        chk("wrap reached", {31'd0, seen_wrap}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipe3_flow_ctrl.md
PIPE3_FLOW_CTRL -- requirements
Module: pipe3_flow_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, data width of operands and result.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 Port: in_valid  input  1  upstream beat present.
REQ-005 Port: in_ready  output  1  block accepts beat this cycle.
REQ-006 Port: in_a  input  WIDTH  operand A.
REQ-007 Port: in_b  input  WIDTH  operand B.
REQ-008 Port: out_valid  output  1  result present in stage 3.
REQ-009 Port: out_ready  input  1  downstream accepts result.
REQ-010 Port: out_data  output  WIDTH  result (in_a AND in_b of the matching beat).
REQ-011 Port: drain  input  1  level request: stop accepting, empty pipeline, hold idle.
REQ-012 Port: idle  output  1  FSM in HALT and pipeline empty.
REQ-013 Port: occ  output  2  number of valid stages, 0..3.
REQ-014 Port: done_cnt  output  16  count of completed output transfers.

Function
REQ-015 Stage S1 SHALL register a1 = in_a and nb1 = ~in_b with valid v1; stage S2 SHALL register d2 = a1 & ~nb1 with v2; stage S3 SHALL register d3 = d2 with v3.
REQ-016 out_data SHALL equal d3 and out_valid SHALL equal v3 (registered, no combinational path from inputs).
REQ-017 Load enables SHALL be ld3 = ~v3 | out_ready, ld2 = ~v2 | ld3, ld1 = ~v1 | ld2 (bubbles collapse; full throughput).
REQ-018 in_ready SHALL equal ld1 AND state==RUN; an input transfer occurs when in_valid & in_ready at a rising edge.
REQ-019 A stage loading with no valid predecessor SHALL clear its valid bit; data registers load only when their valid input is 1.
REQ-020 Latency: beat accepted at edge N SHALL appear with out_valid=1 after edge N+2 when out_ready=1 throughout.
REQ-021 Results SHALL leave in acceptance order; no beat dropped or duplicated under any out_ready pattern.
REQ-022 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-023 occ SHALL equal v1+v2+v3 each cycle.
REQ-024 done_cnt SHALL increment by 1 on each out_valid & out_ready edge, wrapping 0xFFFF -> 0x0000.
REQ-025 FSM states RUN, DRAIN, HALT; RUN -> DRAIN when drain=1; DRAIN -> HALT when occ==0; HALT -> RUN when drain=0; DRAIN with drain=0 SHALL continue to HALT first.
REQ-026 A transfer in the cycle drain first rises SHALL be accepted (state still RUN); in_ready SHALL be 0 in DRAIN and HALT.
REQ-027 Outputs SHALL continue to be delivered during DRAIN per REQ-017.
REQ-028 idle SHALL be 1 only in HALT (occ is 0 there by construction).
REQ-029 RUN -> DRAIN on entering RUN with drain already 1 (e.g. after reset) SHALL transition on the first edge.

Reset
REQ-030 While reset=0: v1=v2=v3=0, all data registers 0, out_data=0, out_valid=0, occ=0, done_cnt=0, state=RUN, idle=0, in_ready=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight beats without producing out_valid.
REQ-032 After reset deasserts, in_ready SHALL be 1 in the first cycle (RUN, empty, drain=0).

Verification
REQ-033 Single beat a=0xF0, b=0x3C, out_ready=1 -> out_valid=1 with out_data=0x30 after accept edge+2, done_cnt=1, occ returns to 0.
REQ-034 10 back-to-back beats, out_ready=1 -> in_ready stays 1, 10 consecutive outputs in order, done_cnt=10.
REQ-035 out_ready=0, in_valid held 1 -> exactly 3 beats accepted, occ=3, in_ready=0; out_ready=1 -> 3 ordered outputs, one per cycle.
REQ-036 drain=1 with occ=2 -> in_ready=0 next cycle, 2 outputs delivered, idle=1 when occ=0; drain=0 -> state RUN, in_ready=1.
REQ-037 reset=0 pulse with occ=3 and done_cnt=5 -> out_valid=0, occ=0, done_cnt=0 immediately, before any clock edge.
REQ-038 65536 transfers from reset -> done_cnt=0x0000 after the last, 0xFFFF one transfer earlier.
